// File: rtl/rv32_mem_pkg.sv
// Shared types and helpers for the RV32 data-memory arbiter.
// Requests arrive as byte addresses; the memory itself is word-indexed.
package rv32_mem_pkg;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } mem_rsp_t;

  typedef enum logic [0:0] {
    PORT_CORE   = 1'b0,
    PORT_LOADER = 1'b1
  } port_e;

  // Word-aligned and inside the memory; anything else is answered with err.
  function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] size_words);
    logic aligned;
    logic in_range;
    aligned  = (addr[1:0] == 2'b00);
    in_range = ({2'b00, addr[31:2]} < size_words);
    return aligned && in_range;
  endfunction

endpackage

// File: rtl/rv32_rr_arb2.sv
// Two-way round-robin arbiter with a loader-owned lock.
// The pointer only moves when both ports contend; a held lock masks port 0.
module rv32_rr_arb2
  import rv32_mem_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic req0_i,
  input  logic req1_i,
  input  logic lock_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  port_e ptr_q, ptr_d;
  logic  lock_q, lock_d;
  logic  lock_active_s;

  // Ownership lapses in the same cycle the loader drops its lock request.
  assign lock_active_s = lock_q && lock_i;

  // State register: priority pointer and lock owner.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q  <= PORT_CORE;
      lock_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      lock_q <= lock_d;
    end
  end

  // Grant pick for the current cycle.
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (lock_active_s) begin
      gnt1_o = req1_i;
    end else if (req0_i && req1_i) begin
      case (ptr_q)
        PORT_CORE:   gnt0_o = 1'b1;
        PORT_LOADER: gnt1_o = 1'b1;
        default:     gnt0_o = 1'b1;
      endcase
    end else begin
      gnt0_o = req0_i;
      gnt1_o = req1_i;
    end
  end

  // Next pointer and lock owner.
  always_comb begin
    ptr_d  = ptr_q;
    lock_d = lock_q;
    if (!lock_active_s && req0_i && req1_i) begin
      ptr_d = (ptr_q == PORT_CORE) ? PORT_LOADER : PORT_CORE;
    end else begin
      ptr_d = ptr_q;
    end
    if (!lock_i) begin
      lock_d = 1'b0;
    end else if (gnt1_o) begin
      lock_d = 1'b1;
    end else begin
      lock_d = lock_q;
    end
  end

endmodule

// File: rtl/rv32_dmem_arbiter.sv
// Shares the single-port data memory between the core LSU and the loader.
// One access per cycle; responses come back one cycle later in grant order.
module rv32_dmem_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int DMEM_SIZE = 512,
  parameter int ADDR_W    = $clog2(DMEM_SIZE)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_be,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_be,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  input  logic              m1_lock,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int OFF_W = $clog2(WORD_BYTES);

  logic     gnt0_s, gnt1_s;
  mem_req_t sel_req_s;
  logic     sel_valid_s;
  port_e    sel_port_s;
  logic     sel_legal_s;
  mem_rsp_t rsp_s;

  logic  rsp_valid_q, rsp_valid_d;
  port_e rsp_port_q,  rsp_port_d;
  logic  rsp_we_q,    rsp_we_d;
  logic  rsp_err_q,   rsp_err_d;

  rv32_rr_arb2 u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .req0_i (m0_req),
    .req1_i (m1_req),
    .lock_i (m1_lock),
    .gnt0_o (gnt0_s),
    .gnt1_o (gnt1_s)
  );

  assign m0_gnt = gnt0_s;
  assign m1_gnt = gnt1_s;

  // Select the winning request.
  always_comb begin
    sel_req_s   = '0;
    sel_valid_s = 1'b0;
    sel_port_s  = PORT_CORE;
    if (gnt1_s) begin
      sel_req_s   = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, be: m1_be};
      sel_valid_s = 1'b1;
      sel_port_s  = PORT_LOADER;
    end else if (gnt0_s) begin
      sel_req_s   = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, be: m0_be};
      sel_valid_s = 1'b1;
      sel_port_s  = PORT_CORE;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  assign sel_legal_s = addr_legal(sel_req_s.addr, 32'(DMEM_SIZE));

  // Memory issue; illegal accesses never strobe the memory.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = sel_req_s.addr[ADDR_W+OFF_W-1:OFF_W];
    mem_wdata = sel_req_s.wdata;
    if (sel_valid_s && sel_legal_s) begin
      mem_en = 1'b1;
      mem_we = sel_req_s.we ? sel_req_s.be : 4'b0000;
    end else begin
      mem_en = 1'b0;
      mem_we = 4'b0000;
    end
  end

  // Response register contents for the access issued this cycle.
  always_comb begin
    rsp_valid_d = sel_valid_s;
    rsp_port_d  = sel_port_s;
    rsp_we_d    = sel_req_s.we;
    rsp_err_d   = sel_valid_s && !sel_legal_s;
  end

  // Response register; reset discards any pending response at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= PORT_CORE;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_port_q  <= rsp_port_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Build the response; only legal reads pass memory data through.
  always_comb begin
    rsp_s.rvalid = rsp_valid_q;
    rsp_s.err    = rsp_valid_q && rsp_err_q;
    if (rsp_valid_q && !rsp_we_q && !rsp_err_q) begin
      rsp_s.rdata = mem_rdata;
    end else begin
      rsp_s.rdata = 32'h0000_0000;
    end
  end

  // Route the response to the port that owns it.
  always_comb begin
    m0_rvalid = 1'b0;
    m0_rdata  = 32'h0000_0000;
    m0_err    = 1'b0;
    m1_rvalid = 1'b0;
    m1_rdata  = 32'h0000_0000;
    m1_err    = 1'b0;
    if (rsp_s.rvalid) begin
      case (rsp_port_q)
        PORT_CORE: begin
          m0_rvalid = 1'b1;
          m0_rdata  = rsp_s.rdata;
          m0_err    = rsp_s.err;
        end
        PORT_LOADER: begin
          m1_rvalid = 1'b1;
          m1_rdata  = rsp_s.rdata;
          m1_err    = rsp_s.err;
        end
        default: begin
          m0_rvalid = 1'b0;
          m1_rvalid = 1'b0;
        end
      endcase
    end else begin
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32_dmem_arbiter.sv
// Directed bench for rv32_dmem_arbiter with a behavioural 512-word memory.
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later.
module tb_rv32_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err, m1_lock;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:511];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv32_dmem_arbiter #(.DMEM_SIZE(512)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .m1_lock(m1_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory: read data valid the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic core(input logic req, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
  endtask

  task automatic ldr(input logic req, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input logic lock);
    m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be; m1_lock = lock;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0000_0000;
    mem[4] = 32'hDEAD_BEEF;
    mem[5] = 32'hCAFE_F00D;
    mem_rdata = 32'h0000_0000;
    rstn = 1'b0;
    core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    ldr(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    cyc(); cyc();
    chk("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
    chk("rst_m1_gnt", {31'b0, m1_gnt}, 32'd0);
    chk("rst_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'd0);
    chk("rst_err",    {30'b0, m0_err, m1_err}, 32'd0);
    chk("rst_rdata",  m0_rdata | m1_rdata, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_we", {28'b0, mem_we}, 32'd0);
    rstn = 1'b1;

    // Core read of word 4
    cyc();
    core(1'b1, 1'b0, 32'h10, 32'h0, 4'hF); #1;
    chk("rd_gnt",      {30'b0, m0_gnt, m1_gnt}, 32'd2);
    chk("rd_mem_en",   {31'b0, mem_en}, 32'd1);
    chk("rd_mem_addr", {23'b0, mem_addr}, 32'd4);
    chk("rd_mem_we",   {28'b0, mem_we}, 32'd0);
    cyc();
    core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    chk("rd_rvalid",   {30'b0, m0_rvalid, m1_rvalid}, 32'd2);
    chk("rd_rdata",    m0_rdata, 32'hDEAD_BEEF);
    chk("rd_err",      {31'b0, m0_err}, 32'd0);
    chk("idle_mem_en", {31'b0, mem_en}, 32'd0);

    // Simultaneous requests: pointer at core, then flipped to loader
    cyc();
    core(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    ldr(1'b1, 1'b0, 32'h14, 32'h0, 4'hF, 1'b0); #1;
    chk("both1_gnt", {30'b0, m0_gnt, m1_gnt}, 32'd2);
    cyc();
    core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    chk("both1_gnt2",   {30'b0, m0_gnt, m1_gnt}, 32'd1);
    chk("both1_rsp0",   {30'b0, m0_rvalid, m1_rvalid}, 32'd2);
    chk("both1_rdata0", m0_rdata, 32'hDEAD_BEEF);
    cyc();
    core(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    ldr(1'b1, 1'b0, 32'h14, 32'h0, 4'hF, 1'b0); #1;
    chk("both1_rsp1",   {30'b0, m0_rvalid, m1_rvalid}, 32'd1);
    chk("both1_rdata1", m1_rdata, 32'hCAFE_F00D);
    chk("both2_gnt",    {30'b0, m0_gnt, m1_gnt}, 32'd1);
    cyc();
    ldr(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0); #1;
    chk("both2_gnt2", {30'b0, m0_gnt, m1_gnt}, 32'd2);
    chk("both2_rsp1", {30'b0, m0_rvalid, m1_rvalid}, 32'd1);
    cyc();
    core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    chk("both2_rsp0", {30'b0, m0_rvalid, m1_rvalid}, 32'd2);

    // Locked loader burst while the core waits
    cyc();
    ldr(1'b1, 1'b1, 32'h0, 32'h1000_0000, 4'hF, 1'b1); #1;
    chk("lk0_gnt",   {30'b0, m0_gnt, m1_gnt}, 32'd1);
    chk("lk0_mem_we", {28'b0, mem_we}, 32'hF);
    chk("lk0_wdata", mem_wdata, 32'h1000_0000);
    for (int i = 1; i < 4; i++) begin
      cyc();
      core(1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
      ldr(1'b1, 1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF, 1'b1); #1;
      chk("lk_gnt",      {30'b0, m0_gnt, m1_gnt}, 32'd1);
      chk("lk_mem_addr", {23'b0, mem_addr}, 32'(i));
      chk("lk_ack",      {29'b0, m1_rvalid, m1_err, m0_rvalid}, 32'd4);
      chk("lk_ack_data", m1_rdata, 32'd0);
    end
    cyc();
    ldr(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1); #1;
    chk("lk_hold_gnt",    {30'b0, m0_gnt, m1_gnt}, 32'd0);
    chk("lk_hold_mem_en", {31'b0, mem_en}, 32'd0);
    cyc();
    m1_lock = 1'b0; #1;
    chk("lk_rel_gnt", {30'b0, m0_gnt, m1_gnt}, 32'd2);
    cyc();
    core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    chk("lk_rd_rvalid", {31'b0, m0_rvalid}, 32'd1);
    chk("lk_rd_data",   m0_rdata, 32'h1000_0000);

    // Illegal accesses: misaligned, out of range, and an out-of-range write
    cyc();
    core(1'b1, 1'b0, 32'h802, 32'h0, 4'hF); #1;
    chk("mis_gnt",    {31'b0, m0_gnt}, 32'd1);
    chk("mis_mem_en", {31'b0, mem_en}, 32'd0);
    cyc();
    core(1'b1, 1'b0, 32'h800, 32'h0, 4'hF); #1;
    chk("oor_gnt",    {31'b0, m0_gnt}, 32'd1);
    chk("oor_mem_en", {31'b0, mem_en}, 32'd0);
    chk("mis_rsp",    {30'b0, m0_rvalid, m0_err}, 32'd3);
    chk("mis_rdata",  m0_rdata, 32'd0);
    cyc();
    core(1'b1, 1'b1, 32'h804, 32'hFFFF_FFFF, 4'hF); #1;
    chk("oorw_mem_we", {28'b0, mem_we}, 32'd0);
    chk("oor_rsp",     {30'b0, m0_rvalid, m0_err}, 32'd3);
    chk("oor_rdata",   m0_rdata, 32'd0);

    // Byte-lane write and readback
    cyc();
    core(1'b1, 1'b1, 32'h20, 32'h1122_3344, 4'b0100); #1;
    chk("oorw_rsp",    {30'b0, m0_rvalid, m0_err}, 32'd3);
    chk("bw_mem_we",   {28'b0, mem_we}, 32'h4);
    chk("bw_mem_addr", {23'b0, mem_addr}, 32'd8);
    cyc();
    core(1'b1, 1'b0, 32'h20, 32'h0, 4'hF); #1;
    chk("bw_ack",      {30'b0, m0_rvalid, m0_err}, 32'd2);
    chk("bw_ack_data", m0_rdata, 32'd0);
    cyc();
    core(1'b1, 1'b0, 32'h4, 32'h0, 4'hF); #1;
    chk("bw_readback", m0_rdata, 32'h0022_0000);
    cyc();
    core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    chk("oorw_no_side_effect", m0_rdata, 32'h1000_0001);

    // Reset while a response is pending
    cyc();
    core(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    ldr(1'b1, 1'b0, 32'h14, 32'h0, 4'hF, 1'b0); #1;
    chk("rm_gnt", {30'b0, m0_gnt, m1_gnt}, 32'd2);
    cyc();
    core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    ldr(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    rstn = 1'b0; #1;
    chk("rm_rvalid_drop", {30'b0, m0_rvalid, m1_rvalid}, 32'd0);
    cyc();
    rstn = 1'b1;
    cyc();
    core(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    ldr(1'b1, 1'b0, 32'h14, 32'h0, 4'hF, 1'b0); #1;
    chk("rm_no_stale", {30'b0, m0_rvalid, m1_rvalid}, 32'd0);
    chk("rm_ptr_core", {30'b0, m0_gnt, m1_gnt}, 32'd2);
    cyc();
    core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    ldr(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0); #1;
    chk("rm_rsp",   {30'b0, m0_rvalid, m1_rvalid}, 32'd2);
    chk("rm_rdata", m0_rdata, 32'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv32_dmem_arbiter.md
Name: rv32_dmem_arbiter

Overview:
Shares the single-port synchronous data memory of RV32_top between two requesters: port 0 is the core load/store unit and port 1 is the program/debug loader. It arbitrates round-robin, with an optional lock that lets the loader hold the memory for bursts. Throughput is one access per cycle; read data returns with fixed 1-cycle latency. Out-of-range and misaligned accesses are flagged instead of reaching memory.

Parameters:
DMEM_SIZE, 512, memory depth in 32-bit words (power of two)
ADDR_W, $clog2(DMEM_SIZE), word-index width on the memory side

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
m0_req  in  1  core access request
m0_we  in  1  core write (1) / read (0)
m0_addr  in  32  core byte address
m0_wdata  in  32  core write data
m0_be  in  4  core byte enables
m0_gnt  out  1  core request accepted this cycle
m0_rvalid  out  1  core response valid
m0_rdata  out  32  core read data
m0_err  out  1  core response error
m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_gnt, m1_rvalid, m1_rdata, m1_err  as m0_*  loader port
m1_lock  in  1  loader holds ownership while asserted
mem_en  out  1  memory access strobe
mem_we  out  4  per-byte write strobes (0 = read)
mem_addr  out  ADDR_W  word index
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid the cycle after mem_en

Behaviour:
- Clock and reset: one clock, clk; reset rstn is asynchronous and active-low.
- Reset values: all gnt/rvalid/err = 0, rdata = 0, mem_en = 0, mem_we = 0, priority pointer = port 0, lock owner = none, response register empty.
- Requester protocol: hold req and all fields stable until gnt. gnt is a one-cycle pulse. A requester may present a new request in the cycle after gnt.
- Arbitration is combinational in cycle N among active reqs:
  - Lock owner is port 1: only port 1 can be granted; port 0 waits even if port 1 is idle.
  - Otherwise, if only one port requests, that port wins.
  - If both request, the port indicated by the priority pointer wins; the pointer then flips to the loser.
- Lock: port 1 becomes lock owner when granted with m1_lock = 1. Ownership is released in the first cycle m1_lock = 0; arbitration in that same cycle is normal.
- Issue (cycle N): winner's gnt = 1; mem_addr = addr[ADDR_W+1:2]; mem_wdata = wdata; mem_we = be if we, else 0.
  - mem_en = 1 only if the access is legal: addr[1:0] == 0 and addr[31:2] < DMEM_SIZE.
- Response register (cycle N+1): records owner, write flag and error.
  - That port's rvalid = 1 for exactly one cycle, for both reads and writes (write = ack).
  - Legal read: rdata = mem_rdata. Write or error: rdata = 0.
  - err = 1 for illegal accesses, which cause no memory side effect.
- Back-to-back: a grant in N+1 coexists with the response for N. Responses stay in grant order; a port never sees two rvalids in one cycle.
- No req: no gnt, mem_en = 0, pointer unchanged.
- Reset mid-operation: a pending response is discarded and rvalid drops immediately. Requests are not replayed.

Decomposition:
- Package rv32_mem_pkg: mem_req_t struct (we, addr, wdata, be), mem_rsp_t struct (rvalid, rdata, err), port index enum PORT_CORE/PORT_LOADER, constant WORD_BYTES = 4.
- One sub-module, rv32_rr_arb2: 2-way round-robin pick with pointer register and lock mask.
- Address check and response register stay in the top.

Test Plan:
- Core read only: m0 read 0x10 (word 4 = 0xDEADBEEF) -> m0_gnt cycle N, mem_addr = 4, m0_rvalid + rdata 0xDEADBEEF at N+1, err = 0.
- Simultaneous requests after reset: both req at N -> m0 granted N, m1 granted N+1, ordered rvalids; repeat both -> m1 wins first (pointer flipped).
- Lock burst: m1_lock = 1, four loader writes to 0x0..0xC with be = 4'hF while m0_req is held -> four consecutive m1 grants, m0 granted only after m1_lock deasserts.
- Errors: m0 read 0x802 (misaligned) and 0x800 (out of range at DMEM_SIZE = 512) -> gnt, mem_en = 0, rvalid with err = 1, rdata = 0.
- Byte write: m0 write 0x20, wdata 0x11223344, be = 4'b0100 -> mem_we = 4'b0100; readback of a word previously 0 gives 0x00220000.
- Reset mid-response: assert rstn = 0 in the cycle after a grant -> rvalid 0 immediately; after release, pointer = port 0 and no stale response.
